// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU and the ALU arbiter: ALU function codes, funct7
// selects and the arbiter state encoding.
package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    ADD_SUB = 3'd0,
    SLL     = 3'd1,
    SLT     = 3'd2,
    SLTU    = 3'd3,
    XOR     = 3'd4,
    SRL_SRA = 3'd5,
    OR      = 3'd6,
    AND     = 3'd7
  } alu_fn_t;

  typedef enum logic [6:0] {
    ADD_SRL = 7'b0000000,
    SUB_SRA = 7'b0100000
  } funct7_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the ALU arbiter.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();

  logic    [NUM_REQ-1:0]            req_valid;
  logic    [NUM_REQ-1:0]            req_ready;
  alu_fn_t [NUM_REQ-1:0]            req_fn;
  funct7_t [NUM_REQ-1:0]            req_funct7;
  logic    [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic    [NUM_REQ-1:0][WIDTH-1:0] req_b;
  logic    [NUM_REQ-1:0]            resp_valid;
  logic    [NUM_REQ-1:0]            resp_ready;
  logic    [WIDTH-1:0]              resp_data;
  logic    [ID_W-1:0]               resp_id;

  modport master (
    output req_valid, req_fn, req_funct7, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_fn, req_funct7, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU: modular WIDTH-bit arithmetic, funct7 selects
// SUB for ADD_SUB and arithmetic shift for SRL_SRA.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_fn_t          i_fn,
  input  funct7_t          i_funct7,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]         w_shamt;
  logic                    w_sub;
  logic signed [WIDTH-1:0] w_sra;

  assign w_shamt = i_b[SH_W-1:0];
  assign w_sub   = (i_funct7 == SUB_SRA);
  // Kept in its own signed net so the shift stays arithmetic.
  assign w_sra   = $signed(i_a) >>> w_shamt;

  always_comb begin
    o_result = {WIDTH{1'b0}};
    case (i_fn)
      ADD_SUB: o_result = w_sub ? (i_a - i_b) : (i_a + i_b);
      SLL:     o_result = i_a << w_shamt;
      SLT:     o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      SLTU:    o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      XOR:     o_result = i_a ^ i_b;
      SRL_SRA: o_result = w_sub ? w_sra : (i_a >> w_shamt);
      OR:      o_result = i_a | i_b;
      AND:     o_result = i_a & i_b;
      default: o_result = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Rotating-priority picker: first requester above i_ptr wins, wrapping to
// the lowest index.
module alu_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  logic w_found;

  // Two passes: indices above the pointer first, then the wrapped ones.
  always_comb begin
    o_gnt   = {NUM_REQ{1'b0}};
    o_idx   = {ID_W{1'b0}};
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i] && (i > int'(i_ptr))) begin
        o_gnt[i] = 1'b1;
        o_idx    = ID_W'(i);
        w_found  = 1'b1;
      end else begin
        w_found  = w_found;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[i] && (i <= int'(i_ptr))) begin
        o_gnt[i] = 1'b1;
        o_idx    = ID_W'(i);
        w_found  = 1'b1;
      end else begin
        w_found  = w_found;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu between NUM_REQ requesters with a registered response.
// Define ALU_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic        clk,
  input  logic        rst,
  alu_arbiter_if.slave bus
);

  arb_state_t         r_state;
  arb_state_t         w_next_state;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_any;
  logic               w_take;
  logic               w_done;
  logic [ID_W-1:0]    w_sel;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [WIDTH-1:0]   r_resp_data;
  logic [ID_W-1:0]    r_resp_id;
  alu_fn_t            w_alu_fn;
  funct7_t            w_alu_funct7;
  logic [WIDTH-1:0]   w_alu_a;
  logic [WIDTH-1:0]   w_alu_b;
  logic [WIDTH-1:0]   w_alu_out;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest-index valid requester.
  always_comb begin
    w_gnt_oh  = {NUM_REQ{1'b0}};
    w_gnt_idx = {ID_W{1'b0}};
    w_any     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_any && bus.req_valid[i]) begin
        w_gnt_oh[i] = 1'b1;
        w_gnt_idx   = ID_W'(i);
        w_any       = 1'b1;
      end else begin
        w_any       = w_any;
      end
    end
  end
`else
  logic [ID_W-1:0] r_rr_ptr;

  alu_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt_oh),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  // Reset value makes requester 0 the first winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= ID_W'(NUM_REQ - 1);
    end else if (w_take) begin
      r_rr_ptr <= w_gnt_idx;
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end
`endif

  assign w_take         = (r_state == IDLE) && w_any;
  assign w_done         = (r_state == RESP) && bus.resp_ready[r_resp_id];
  assign w_sel          = w_take ? w_gnt_idx : {ID_W{1'b0}};
  assign bus.req_ready  = w_take ? w_gnt_oh : {NUM_REQ{1'b0}};
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_id    = r_resp_id;

  assign w_alu_fn     = bus.req_fn[w_sel];
  assign w_alu_funct7 = bus.req_funct7[w_sel];
  assign w_alu_a      = bus.req_a[w_sel];
  assign w_alu_b      = bus.req_b[w_sel];

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_fn     (w_alu_fn),
    .i_funct7 (w_alu_funct7),
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next_state = RESP;
        end else begin
          w_next_state = IDLE;
        end
      end
      RESP: begin
        if (w_done) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Response registers are held untouched for the whole RESP phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= {NUM_REQ{1'b0}};
      r_resp_data  <= {WIDTH{1'b0}};
      r_resp_id    <= {ID_W{1'b0}};
    end else if (w_take) begin
      r_resp_valid <= w_gnt_oh;
      r_resp_data  <= w_alu_out;
      r_resp_id    <= w_gnt_idx;
    end else if (w_done) begin
      r_resp_valid <= {NUM_REQ{1'b0}};
    end else begin
      r_resp_valid <= r_resp_valid;
    end
  end

endmodule
